cb_filter_sweep: RTL and testbench
==================================

# cb_filter_sweep

Parametrised counting Bloom filter with per-hash seeds, saturating bucket counters, and a sequential clear engine. It generalises the seeded filter to any hash count and counter width, and adds sticky error reporting and a multi-cycle flush. It sits beside the other common cells as a membership tracker, for example for outstanding transaction IDs or address sets. Seeds use the `cb_seed_t` type from `cb_filter_pkg`.

## Interface
- `KHashes`, 3: number of hash functions; must be ≥1.
- `HashWidth`, 4: bucket index width; bucket count `NoBuckets = 2**HashWidth`.
- `HashRounds`, 1: permute/xor rounds per hash.
- `InpWidth`, 32: width of hashed data.
- `BucketWidth`, 4: counter width per bucket; max value `2**BucketWidth-1`.
- `Seeds`, `cb_filter_pkg::EgSeeds`: `cb_seed_t [KHashes-1:0]`, one seed per hash; seeds must be distinct.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `look_data_i`  in  InpWidth  data to test for membership.
- `look_hit_o`  out  1  all KHashes indexed buckets are nonzero (combinational).
- `incr_data_i`  in  InpWidth  data to insert.
- `incr_valid_i`  in  1  insert request.
- `decr_data_i`  in  InpWidth  data to remove.
- `decr_valid_i`  in  1  remove request.
- `clear_i`  in  1  start flush.
- `busy_o`  out  1  flush in progress.
- `usage_o`  out  HashWidth+1  number of nonzero buckets.
- `full_o`  out  1  `usage_o == NoBuckets`.
- `empty_o`  out  1  `usage_o == 0`.
- `error_o`  out  1  sticky: a saturation or underflow occurred.

## Operation
- Hashing: each hash k maps data to a HashWidth index using the codebase's permute-then-xor sub-hash with `Seeds[k]` and `HashRounds`. There are three independent hash sets: look, incr and decr.
- Per bucket b in IDLE:
  - `inc_b` = OR over k of (`incr_valid_i` & idx_incr[k]==b).
  - `dec_b` = OR over k of (`decr_valid_i` & idx_decr[k]==b).
  - If `inc_b & !dec_b`: counter +1. If `dec_b & !inc_b`: counter -1. If both or neither: counter holds.
  - Hash collisions within one datum change the bucket by 1, not 2.
- Saturation: increment at max holds the counter at max and sets `error_o`. Decrement at 0 holds the counter at 0 and sets `error_o`.
- FSM states:
  - IDLE: on `clear_i`, go to CLEAR with sweep index 0. Incr/decr requests in that same cycle are dropped.
  - CLEAR: each cycle, zero the bucket at the sweep index and increment the index. After bucket NoBuckets-1, go to IDLE and clear `error_o` on that edge.
  - During CLEAR: incr/decr are ignored, `clear_i` is ignored, and `look_hit_o` is forced 0.
- `usage_o`, `full_o` and `empty_o` are derived combinationally from the registered counters. During CLEAR they fall as buckets are zeroed.

## Timing
- Reset values:
  - All counters 0; FSM in IDLE; sweep index 0.
  - `error_o`=0, `busy_o`=0, `usage_o`=0, `full_o`=0, `empty_o`=1, `look_hit_o`=0.
- Insert/remove latency is one edge. A request sampled at edge N is visible on `look_hit_o` and `usage_o` from cycle N+1. A lookup in the same cycle as an insert of the same data sees the pre-insert state.
- `error_o` rises the cycle after the offending edge and stays high until the end of a flush or reset.
- Flush latency is exactly NoBuckets cycles:
  - `busy_o` rises the cycle after `clear_i` is sampled, stays high NoBuckets cycles, then falls.
  - The first incr accepted is in the cycle `busy_o` is low again.
- Reset asserted mid-flush aborts the flush immediately: all state returns to reset values.
- Simultaneous incr and decr of the same datum leave every counter unchanged and set no error.

## Test plan
- After reset with defaults (KHashes=3, HashWidth=4, BucketWidth=4) -> `empty_o`=1, `usage_o`=0, `look_hit_o`=0 for data 0x0000_0000 and 0xDEAD_BEEF.
- Insert 0xDEAD_BEEF, then look it up -> `look_hit_o`=1 from the next cycle. `usage_o` equals the number of distinct hash indices (1..3). Decrement it once -> `empty_o`=1 and hit=0.
- Insert 0x1234 sixteen times (BucketWidth=4) -> its counters saturate at 15 and `error_o`=1 after the 16th edge. Decrement fifteen times -> still hit=0 only after all 15, and the error stays sticky.
- Decrement 0x55 on an empty filter -> counters stay 0 and `error_o`=1 next cycle.
- Insert 20 random data, then pulse `clear_i` -> `busy_o`=1 for exactly 16 cycles, with hit forced 0 throughout and `incr_valid_i` ignored. Afterwards `empty_o`=1 and `error_o`=0.
- Simultaneous incr and decr of 0xABCD on a filter holding it once -> counters unchanged, hit stays 1, no error. Assert `rst_i` in flush cycle 5 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cb_filter_sweep.sv
// Counting Bloom filter with per-hash seeds, saturating bucket counters and a
// sequential clear engine that zeroes one bucket per cycle.
package cb_filter_pkg;

    typedef struct packed {
        logic [31:0] permSeed;
        logic [31:0] xorSeed;
    } cb_seed_t;

    localparam cb_seed_t [2:0] EgSeeds = {
        64'h0000_0007_A5C3_1E97,
        64'h0000_0013_3C6E_F372,
        64'h0000_001D_9E37_79B9
    };

    // Permute-then-xor sub-hash; data up to 128 bits, at most 8 rounds, result folded to hashW bits.
    function automatic logic [31:0] subHash(input logic [127:0] data, input int inpW,
                                            input int hashW, input int rounds,
                                            input cb_seed_t seed);
        logic [127:0] cur;
        logic [127:0] nxt;
        logic [31:0]  res;
        int           rot;
        cur = data;
        for (int r = 0; r < 8; r++) begin
            if (r < rounds) begin
                rot = (int'(seed.permSeed[7:0]) + 3 * r) % inpW;
                nxt = '0;
                for (int i = 0; i < 128; i++) begin
                    if (i < inpW) begin
                        nxt[i] = cur[(i + rot) % inpW] ^ seed.xorSeed[(i + r) % 32]
                               ^ (cur[(i + 5) % inpW] & cur[(i + 11) % inpW]);
                    end
                end
                cur = nxt;
            end
        end
        res = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < inpW) begin
                res[i % hashW] = res[i % hashW] ^ cur[i];
            end
        end
        return res;
    endfunction

endpackage

module cb_filter_sweep #(
    parameter int KHashes     = 3,
    parameter int HashWidth   = 4,
    parameter int HashRounds  = 1,
    parameter int InpWidth    = 32,
    parameter int BucketWidth = 4,
    parameter cb_filter_pkg::cb_seed_t [KHashes-1:0] Seeds = cb_filter_pkg::EgSeeds
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [InpWidth-1:0]  look_data_i,
    output logic                 look_hit_o,
    input  logic [InpWidth-1:0]  incr_data_i,
    input  logic                 incr_valid_i,
    input  logic [InpWidth-1:0]  decr_data_i,
    input  logic                 decr_valid_i,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic [HashWidth:0]   usage_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 error_o
);

    localparam int NoBuckets = 2 ** HashWidth;
    localparam logic [BucketWidth-1:0] CountMax = {BucketWidth{1'b1}};

    typedef enum logic {StIdle, StClear} state_e;

    state_e                 state_q;
    logic [HashWidth-1:0]   sweep_q;
    logic                   busy_q;
    logic                   error_q;
    logic [BucketWidth-1:0] counters_q [NoBuckets];

    logic [HashWidth-1:0]   idxLook [KHashes];
    logic [HashWidth-1:0]   idxIncr [KHashes];
    logic [HashWidth-1:0]   idxDecr [KHashes];
    logic [NoBuckets-1:0]   incBucket;
    logic [NoBuckets-1:0]   decBucket;
    logic [HashWidth:0]     usageCount;
    logic                   lookHit;

    function automatic logic [HashWidth-1:0] hashIdx(input logic [InpWidth-1:0] data, input int k);
        logic [31:0] h;
        h = cb_filter_pkg::subHash(128'(data), InpWidth, HashWidth, HashRounds, Seeds[k]);
        return h[HashWidth-1:0];
    endfunction

    always_comb begin
        incBucket = '0;
        decBucket = '0;
        for (int k = 0; k < KHashes; k++) begin
            idxLook[k] = hashIdx(look_data_i, k);
            idxIncr[k] = hashIdx(incr_data_i, k);
            idxDecr[k] = hashIdx(decr_data_i, k);
            if (incr_valid_i) incBucket[idxIncr[k]] = 1'b1;
            if (decr_valid_i) decBucket[idxDecr[k]] = 1'b1;
        end
    end

    // Lookups are blanked while the sweep is running, since buckets are half-cleared.
    always_comb begin
        lookHit    = (state_q == StIdle);
        usageCount = '0;
        for (int k = 0; k < KHashes; k++) begin
            if (counters_q[idxLook[k]] == '0) lookHit = 1'b0;
        end
        for (int b = 0; b < NoBuckets; b++) begin
            usageCount = usageCount + {{HashWidth{1'b0}}, |counters_q[b]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sweep_q <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            for (int b = 0; b < NoBuckets; b++) counters_q[b] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        state_q <= StClear;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        for (int b = 0; b < NoBuckets; b++) begin
                            if (incBucket[b] && !decBucket[b]) begin
                                if (counters_q[b] == CountMax) error_q <= 1'b1;
                                else counters_q[b] <= counters_q[b] + 1'b1;
                            end else if (decBucket[b] && !incBucket[b]) begin
                                if (counters_q[b] == '0) error_q <= 1'b1;
                                else counters_q[b] <= counters_q[b] - 1'b1;
                            end
                        end
                    end
                end
                StClear: begin
                    counters_q[sweep_q] <= '0;
                    sweep_q             <= sweep_q + 1'b1;
                    if (sweep_q == HashWidth'(NoBuckets - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign look_hit_o = lookHit;
    assign busy_o     = busy_q;
    assign error_o    = error_q;
    assign usage_o    = usageCount;
    assign full_o     = (usageCount == (HashWidth + 1)'(NoBuckets));
    assign empty_o    = (usageCount == '0);

endmodule

// File: tb/tb_cb_filter_sweep.sv
// Scoreboard bench for cb_filter_sweep: a bucket-level model predicts every output
// for the cycle after each stimulus and the results are compared once the edge has passed.
module tb_cb_filter_sweep;

    localparam cb_filter_pkg::cb_seed_t [2:0] BenchSeeds = cb_filter_pkg::EgSeeds;

    logic        clock;
    logic        rst;
    logic [31:0] lookData;
    logic        lookHit;
    logic [31:0] incrData;
    logic        incrValid;
    logic [31:0] decrData;
    logic        decrValid;
    logic        clear;
    logic        busy;
    logic [4:0]  usage;
    logic        full;
    logic        empty;
    logic        error;

    typedef struct {
        bit hit;
        int usage;
        bit empty;
        bit full;
        bit err;
        bit busy;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      errors = 0;

    int mCount [16];
    bit mBusy;
    bit mErr;
    int mSweep;

    cb_filter_sweep dut (
        .clk_i        (clock),
        .rst_i        (rst),
        .look_data_i  (lookData),
        .look_hit_o   (lookHit),
        .incr_data_i  (incrData),
        .incr_valid_i (incrValid),
        .decr_data_i  (decrData),
        .decr_valid_i (decrValid),
        .clear_i      (clear),
        .busy_o       (busy),
        .usage_o      (usage),
        .full_o       (full),
        .empty_o      (empty),
        .error_o      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int hIdx(input int k, input logic [31:0] d);
        logic [31:0] h;
        h = cb_filter_pkg::subHash({96'b0, d}, 32, 4, 1, BenchSeeds[k]);
        return int'(h[3:0]);
    endfunction

    function automatic int distinctIdx(input logic [31:0] d);
        bit seen [16];
        int n;
        n = 0;
        for (int b = 0; b < 16; b++) seen[b] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!seen[hIdx(k, d)]) n++;
            seen[hIdx(k, d)] = 1'b1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 16; b++) mCount[b] = 0;
        mBusy  = 1'b0;
        mErr   = 1'b0;
        mSweep = 0;
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge and queue the prediction.
    task automatic applyStimulus(input logic [31:0] look, input logic [31:0] incD, input bit incV,
                                 input logic [31:0] decD, input bit decV, input bit clr);
        bit      inc [16];
        bit      dec [16];
        expect_t e;
        lookData  = look;
        incrData  = incD;
        incrValid = incV;
        decrData  = decD;
        decrValid = decV;
        clear     = clr;
        if (!mBusy) begin
            if (clr) begin
                mBusy  = 1'b1;
                mSweep = 0;
            end else begin
                for (int b = 0; b < 16; b++) begin
                    inc[b] = 1'b0;
                    dec[b] = 1'b0;
                end
                for (int k = 0; k < 3; k++) begin
                    if (incV) inc[hIdx(k, incD)] = 1'b1;
                    if (decV) dec[hIdx(k, decD)] = 1'b1;
                end
                for (int b = 0; b < 16; b++) begin
                    if (inc[b] && !dec[b]) begin
                        if (mCount[b] == 15) mErr = 1'b1;
                        else mCount[b]++;
                    end else if (dec[b] && !inc[b]) begin
                        if (mCount[b] == 0) mErr = 1'b1;
                        else mCount[b]--;
                    end
                end
            end
        end else begin
            mCount[mSweep] = 0;
            if (mSweep == 15) begin
                mBusy = 1'b0;
                mErr  = 1'b0;
            end
            mSweep++;
        end
        e.hit   = !mBusy;
        for (int k = 0; k < 3; k++) if (mCount[hIdx(k, look)] == 0) e.hit = 1'b0;
        e.usage = 0;
        for (int b = 0; b < 16; b++) if (mCount[b] != 0) e.usage++;
        e.empty = (e.usage == 0);
        e.full  = (e.usage == 16);
        e.err   = mErr;
        e.busy  = mBusy;
        sb.push_back(e);
    endtask

    task automatic advanceCycle();
        expect_t e;
        @(posedge clock);
        #1;
        if (sb.size() != 1) begin
            checkOutput("sbDepth", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            checkOutput("hit", int'(lookHit), int'(e.hit));
            checkOutput("usage", int'(usage), e.usage);
            checkOutput("empty", int'(empty), int'(e.empty));
            checkOutput("full", int'(full), int'(e.full));
            checkOutput("error", int'(error), int'(e.err));
            checkOutput("busy", int'(busy), int'(e.busy));
        end
    endtask

    task automatic idleCycle(input logic [31:0] look);
        applyStimulus(look, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        advanceCycle();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Empty"}, int'(empty), 1);
        checkOutput({tag, "Usage"}, int'(usage), 0);
        checkOutput({tag, "Hit"}, int'(lookHit), 0);
        checkOutput({tag, "Error"}, int'(error), 0);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "Full"}, int'(full), 0);
    endtask

    initial begin
        int          busyCycles;
        int          guard;
        logic [31:0] randData;

        rst       = 1'b1;
        lookData  = 32'h0;
        incrData  = 32'h0;
        incrValid = 1'b0;
        decrData  = 32'h0;
        decrValid = 1'b0;
        clear     = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        #1;
        checkResetValues("rst0");
        lookData = 32'hDEAD_BEEF;
        #1;
        checkOutput("rstHitDead", int'(lookHit), 0);

        // Insert with a same-cycle lookup that must still see the empty filter.
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("preInsertHit", int'(lookHit), 0);
        advanceCycle();
        checkOutput("deadUsage", int'(usage), distinctIdx(32'hDEAD_BEEF));
        applyStimulus(32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        advanceCycle();
        checkOutput("deadRemovedEmpty", int'(empty), 1);

        // Saturate 0x1234, then walk it back down; the error stays sticky.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(32'h1234, 32'h1234, 1'b1, 32'h0, 1'b0, 1'b0);
            advanceCycle();
        end
        checkOutput("satError", int'(error), 1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(32'h1234, 32'h0, 1'b0, 32'h1234, 1'b1, 1'b0);
            advanceCycle();
            checkOutput("satDrainHit", int'(lookHit), (i < 14) ? 1 : 0);
        end
        checkOutput("satStickyError", int'(error), 1);

        applyStimulus(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        advanceCycle();
        for (int i = 0; i < 16; i++) idleCycle(32'h0);
        checkOutput("flushClearsError", int'(error), 0);

        applyStimulus(32'h55, 32'h0, 1'b0, 32'h55, 1'b1, 1'b0);
        advanceCycle();
        checkOutput("underflowError", int'(error), 1);
        checkOutput("underflowEmpty", int'(empty), 1);

        // Twenty random inserts, then a flush with inserts attempted throughout.
        for (int i = 0; i < 20; i++) begin
            randData = $urandom;
            applyStimulus(randData, randData, 1'b1, 32'h0, 1'b0, 1'b0);
            advanceCycle();
        end
        applyStimulus(randData, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        advanceCycle();
        busyCycles = busy ? 1 : 0;
        guard = 0;
        while (busy && guard < 40) begin
            applyStimulus(randData, $urandom, 1'b1, 32'h0, 1'b0, 1'b0);
            advanceCycle();
            if (busy) begin
                busyCycles++;
                checkOutput("flushHitForced", int'(lookHit), 0);
            end
            guard++;
        end
        checkOutput("busyCycles", busyCycles, 16);
        checkOutput("postFlushEmpty", int'(empty), 1);
        checkOutput("postFlushError", int'(error), 0);
        idleCycle(32'h0);

        // Simultaneous insert and remove of a held datum changes nothing.
        applyStimulus(32'hABCD, 32'hABCD, 1'b1, 32'h0, 1'b0, 1'b0);
        advanceCycle();
        applyStimulus(32'hABCD, 32'hABCD, 1'b1, 32'hABCD, 1'b1, 1'b0);
        advanceCycle();
        checkOutput("incDecHit", int'(lookHit), 1);
        checkOutput("incDecUsage", int'(usage), distinctIdx(32'hABCD));
        checkOutput("incDecError", int'(error), 0);

        // Abort a flush in its fifth cycle with reset.
        applyStimulus(32'hABCD, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        advanceCycle();
        for (int i = 0; i < 4; i++) idleCycle(32'hABCD);
        checkOutput("midFlushBusy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkResetValues("abort");
        @(posedge clock);
        #1;
        rst = 1'b0;
        idleCycle(32'hABCD);
        checkOutput("abortStaysIdle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
